// File: rtl/spi_in_capture.sv
// Oversampling SPI receiver: synchronizes CS/SCLK/DATA_IN into CLK, deserializes words
// and buffers them in a first-word-fall-through FIFO with framing and overflow reporting.
module spi_in_capture #(
  parameter int WORD_BITS   = 16,
  parameter int LSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SCLK,
  input  logic                 CS,
  input  logic                 DATA_IN,
  output logic [WORD_BITS-1:0] OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 FRAME_DONE,
  output logic [7:0]           FRAME_WORDS,
  output logic                 FRAME_ERR,
  output logic                 OVERFLOW
);

  localparam int BW = $clog2(WORD_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic logic [WORD_BITS-1:0] shift_in(input logic [WORD_BITS-1:0] cur,
                                                    input logic bit_in);
    if (LSB_FIRST != 0) return {bit_in, cur[WORD_BITS-1:1]};
    else                return {cur[WORD_BITS-2:0], bit_in};
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, data_sync;
  logic [SYNC_STAGES:0]   fill;
  logic                   sclk_d, armed, frame_act;
  logic                   sclk_s, cs_s, data_s, sync_ok;
  logic                   frame_start, frame_end, rise_p0, word_end_p0;
  logic [BW-1:0]          bit_cnt;
  logic [7:0]             word_cnt;
  logic [WORD_BITS-1:0]   shreg_p0;
  logic                   push_vld_p1;

  logic [WORD_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   full, empty, pop, wr_en;

  // Stage: synchronizers plus a fill tracker so reset values are never mistaken for pin state
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      data_sync <= '0;
      sclk_d    <= 1'b0;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      data_sync <= {data_sync[SYNC_STAGES-2:0], DATA_IN};
      sclk_d    <= sclk_s;
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_comb begin
    sclk_s      = sclk_sync[SYNC_STAGES-1];
    cs_s        = cs_sync[SYNC_STAGES-1];
    data_s      = data_sync[SYNC_STAGES-1];
    sync_ok     = fill[SYNC_STAGES];
    // A frame only opens after CS has genuinely been seen high, so a frame cut by reset stays ignored
    frame_start = sync_ok & armed & ~frame_act & ~cs_s;
    frame_end   = frame_act & cs_s;
    rise_p0     = frame_act & ~cs_s & sclk_s & ~sclk_d;
    word_end_p0 = rise_p0 & (bit_cnt == BW'(WORD_BITS - 1));
  end

  // Stage p0: bit/word counting and frame status
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed       <= 1'b0;
      frame_act   <= 1'b0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      push_vld_p1 <= 1'b0;
      FRAME_DONE  <= 1'b0;
      FRAME_ERR   <= 1'b0;
      FRAME_WORDS <= '0;
    end else begin
      FRAME_DONE  <= 1'b0;
      FRAME_ERR   <= 1'b0;
      push_vld_p1 <= word_end_p0;
      armed       <= armed | (sync_ok & cs_s);
      if (frame_start) begin
        frame_act <= 1'b1;
        bit_cnt   <= '0;
        word_cnt  <= '0;
      end else if (frame_end) begin
        frame_act <= 1'b0;
        if (bit_cnt != '0) begin
          FRAME_ERR   <= 1'b1;
          FRAME_WORDS <= word_cnt;
        end else if (word_cnt != '0) begin
          FRAME_DONE  <= 1'b1;
          FRAME_WORDS <= word_cnt;
        end
      end else if (rise_p0) begin
        bit_cnt <= word_end_p0 ? '0 : bit_cnt + BW'(1);
        if (word_end_p0 && word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rise_p0) shreg_p0 <= shift_in(shreg_p0, data_s);
  end

  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    OUT_VALID = ~empty;
    OUT_DATA  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    pop       = OUT_VALID & OUT_READY;
    wr_en     = push_vld_p1 & (~full | pop);
  end

  // Stage p1: completed word enters the FWFT FIFO
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_vld_p1 && full && !pop) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg_p0;
  end

endmodule

// File: doc/spi_in_capture.md
# spi_in_capture

Oversampling SPI receiver that deserializes the CS/SCLK/DATA stream produced by the board's SPI output stage back into parallel words in the CLK domain. It sits directly downstream of the SPI transmitter and is used for FPGA loopback checks of FFT result streaming and as the input stage of the host-side capture path. Words are buffered in a small first-word-fall-through FIFO and presented on a valid/ready interface, with framing-error and overflow reporting.

## Interface
- WORD_BITS, 16: bits per word; 2..32.
- LSB_FIRST, 1: 1 = first received bit is bit 0; 0 = first bit is bit WORD_BITS-1.
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2: synchronizer flops on SCLK, CS, DATA_IN; ≥2.
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- SCLK  in  1  serial clock, asynchronous to CLK; data sampled on its rising edge.
- CS  in  1  chip select, active low, asynchronous.
- DATA_IN  in  1  serial data, asynchronous.
- OUT_DATA  out  WORD_BITS  FIFO head word.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  consumer accepts OUT_DATA when OUT_VALID & OUT_READY.
- FRAME_DONE  out  1  one-cycle pulse on CS deassertion after ≥1 complete word.
- FRAME_WORDS  out  8  complete words in last frame; saturates at 255; updated with FRAME_DONE.
- FRAME_ERR  out  1  one-cycle pulse: CS deasserted with a partial word.
- OVERFLOW  out  1  sticky: a completed word was dropped because FIFO full.

## Operation
- SCLK, CS, DATA_IN each pass through SYNC_STAGES flops; sync flops reset to SCLK=0, CS=1, DATA=0.
- Rising edge = sclk_s & ~sclk_d (one extra delay flop). Ignored while cs_s = 1.
- CS falling edge (cs_d=1, cs_s=0): bit counter and word counter cleared.
- On each qualified rising edge: DATA value (same sync depth) shifted in; LSB_FIRST=1 shifts right inserting at MSB so first bit lands in bit 0 after WORD_BITS bits; LSB_FIRST=0 shifts left inserting at bit 0.
- Bit counter reaching WORD_BITS: word pushed to FIFO next cycle, bit counter wraps to 0, frame word counter increments (saturating 255). Multiple words per frame allowed.
- Push while full and no pop same cycle: word dropped, OVERFLOW set until RST. Push and pop in same cycle while full: both happen, no overflow. Push and pop while empty: not possible (OUT_VALID low).
- CS rising edge: bit counter = 0 → FRAME_DONE pulse if word counter > 0, FRAME_WORDS latched; bit counter ≠ 0 → FRAME_ERR pulse, partial discarded, completed words of the frame stay in FIFO, FRAME_WORDS latched, no FRAME_DONE. Empty frame (no edges): no pulse.
- RST mid-frame: shift register, counters, FIFO flushed; the remainder of the current frame is ignored until a new CS falling edge is seen (sync CS reset to 1 guarantees this only if CS goes high first; a frame in progress at reset release is ignored until CS high→low).

## Timing
- Reset values: OUT_DATA 0, OUT_VALID 0, FRAME_DONE 0, FRAME_WORDS 0, FRAME_ERR 0, OVERFLOW 0.
- SCLK high and low phases ≥ 2 CLK cycles each; DATA_IN stable from 1 CLK before to 1 CLK after SCLK rising; CS setup/hold to first/last SCLK edge ≥ 2 CLK.
- Latency: last SCLK rising at pin → OUT_VALID high after SYNC_STAGES + 2 CLK (SYNC_STAGES + 1 detect, +1 push).
- CS rising at pin → FRAME_DONE/FRAME_ERR after SYNC_STAGES + 1 CLK, after any final push.
- OUT_DATA stable while OUT_VALID & ~OUT_READY; FWFT: next word visible cycle after pop.
- Throughput: one word per WORD_BITS SCLK periods; FIFO pop one per CLK.

## Test plan
- Single frame, LSB_FIRST=1, bits of 16'h0F0F sent bit0 first, OUT_READY=1 → one OUT_DATA=16'h0F0F beat, FRAME_DONE with FRAME_WORDS=1, no FRAME_ERR.
- Frame of 3 words 16'h0F0F, 16'h335A, 16'hFFFF with OUT_READY=0, then READY=1 → three beats in order, FRAME_WORDS=3; LSB_FIRST=0 rerun with MSB-first stimulus gives same words.
- 5 words with OUT_READY=0, FIFO_DEPTH=4 → 4 words held, 5th dropped, OVERFLOW=1 and stays 1; popping yields first four words.
- Frame of 16 bits then 9 bits, CS high → one word out, FRAME_ERR pulse, no FRAME_DONE, FRAME_WORDS=1.
- SCLK toggling with CS high, 20 edges → no FIFO push, no pulses.
- RST asserted after 8 bits of a frame, released, new frame 16'h1234 → only 16'h1234 output, all flags 0 before it.
